// File: rtl/hermes_input_buffer_pkg.sv
// Hermes router shared types and sizing constants.
// Provides the input-buffer FSM state type and default widths.
package HermesPkg;

  localparam int HERMES_FLIT_SIZE   = 32;
  localparam int HERMES_BUFFER_SIZE = 8;
  localparam int HERMES_NPORT       = 5;

  typedef enum logic [2:0] {
    S_IDLE,
    S_REQ,
    S_HEADER,
    S_SIZE,
    S_PAYLOAD
  } hermes_buffer_state_t;

endpackage

// File: rtl/hermes_input_buffer_if.sv
// Input-buffer bus: upstream flit link, routing request, crossbar link.
// master = router side driving flits/acks; slave = the input buffer.
interface hermes_input_buffer_if
  import HermesPkg::*;
#(
  parameter int FLIT_SIZE = HERMES_FLIT_SIZE
);

  logic                 rx_i;
  logic [FLIT_SIZE-1:0] data_i;
  logic                 credit_o;
  logic                 h_o;
  logic                 ack_h_i;
  logic                 data_av_o;
  logic [FLIT_SIZE-1:0] data_o;
  logic                 data_ack_i;
  logic                 sending_o;

  modport master (
    output rx_i,
    output data_i,
    output ack_h_i,
    output data_ack_i,
    input  credit_o,
    input  h_o,
    input  data_av_o,
    input  data_o,
    input  sending_o
  );

  modport slave (
    input  rx_i,
    input  data_i,
    input  ack_h_i,
    input  data_ack_i,
    output credit_o,
    output h_o,
    output data_av_o,
    output data_o,
    output sending_o
  );

endinterface

// File: rtl/hermes_input_buffer_fifo.sv
// Circular flit storage with wrapping pointers and occupancy count.
// Ports: wr_i/data_i push, rd_i pop, head_o, full_o, empty_o.
module hermes_fifo
  import HermesPkg::*;
#(
  parameter int FLIT_SIZE   = HERMES_FLIT_SIZE,
  parameter int BUFFER_SIZE = HERMES_BUFFER_SIZE
) (
  input  logic                 clk_i,
  input  logic                 rst_ni,
  input  logic                 wr_i,
  input  logic [FLIT_SIZE-1:0] data_i,
  input  logic                 rd_i,
  output logic [FLIT_SIZE-1:0] head_o,
  output logic                 full_o,
  output logic                 empty_o
);

  localparam int AW = $clog2(BUFFER_SIZE);
  localparam int CW = AW + 1;
  localparam logic [CW-1:0] DEPTH = CW'(BUFFER_SIZE);

  logic [FLIT_SIZE-1:0] mem_q [BUFFER_SIZE];
  logic [AW-1:0] wr_ptr_q, wr_ptr_d;
  logic [AW-1:0] rd_ptr_q, rd_ptr_d;
  logic [CW-1:0] count_q, count_d;

  always_comb begin
    wr_ptr_d = wr_ptr_q;
    rd_ptr_d = rd_ptr_q;
    count_d  = count_q;
    if (wr_i) wr_ptr_d = wr_ptr_q + AW'(1);
    if (rd_i) rd_ptr_d = rd_ptr_q + AW'(1);
    unique case (1'b1)
      wr_i && !rd_i: count_d = count_q + CW'(1);
      rd_i && !wr_i: count_d = count_q - CW'(1);
      default: ;
    endcase
  end

  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
      count_q  <= '0;
    end else begin
      wr_ptr_q <= wr_ptr_d;
      rd_ptr_q <= rd_ptr_d;
      count_q  <= count_d;
    end
  end

  // Storage is deliberately left unreset.
  always_ff @(posedge clk_i) begin
    if (wr_i) mem_q[wr_ptr_q] <= data_i;
  end

  assign head_o  = mem_q[rd_ptr_q];
  assign full_o  = (count_q == DEPTH);
  assign empty_o = (count_q == '0);

endmodule

// File: rtl/hermes_input_buffer.sv
// Hermes per-port input buffer: FIFO, route request and packet tracking.
// Ports: clk_i, rst_ni, bus (slave) carrying flit, route and crossbar links.
module hermes_input_buffer
  import HermesPkg::*;
#(
  parameter int FLIT_SIZE   = HERMES_FLIT_SIZE,
  parameter int BUFFER_SIZE = HERMES_BUFFER_SIZE
) (
  input  logic                  clk_i,
  input  logic                  rst_ni,
  hermes_input_buffer_if.slave  bus
);

  hermes_buffer_state_t state_q, state_d;
  logic [FLIT_SIZE-1:0] flits_left_q, flits_left_d;
  logic [FLIT_SIZE-1:0] head;
  logic full, empty;
  logic in_pkt, data_av, wr, rd;

  // Credit depends only on the registered count, never on a same-cycle read.
  assign wr = bus.rx_i & ~full;
  assign rd = data_av & bus.data_ack_i;

  hermes_fifo #(
    .FLIT_SIZE   (FLIT_SIZE),
    .BUFFER_SIZE (BUFFER_SIZE)
  ) u_fifo (
    .clk_i   (clk_i),
    .rst_ni  (rst_ni),
    .wr_i    (wr),
    .data_i  (bus.data_i),
    .rd_i    (rd),
    .head_o  (head),
    .full_o  (full),
    .empty_o (empty)
  );

  assign in_pkt = (state_q == S_HEADER) ||
                  (state_q == S_SIZE) ||
                  (state_q == S_PAYLOAD);
  assign data_av = in_pkt & ~empty;

  assign bus.credit_o  = ~full;
  assign bus.h_o       = (state_q == S_REQ);
  assign bus.data_av_o = data_av;
  assign bus.data_o    = data_av ? head : '0;
  assign bus.sending_o = in_pkt;

  always_comb begin
    state_d      = state_q;
    flits_left_d = flits_left_q;
    unique case (state_q)
      S_IDLE: begin
        if (!empty) state_d = S_REQ;
      end
      S_REQ: begin
        if (bus.ack_h_i) state_d = S_HEADER;
      end
      S_HEADER: begin
        if (rd) state_d = S_SIZE;
      end
      S_SIZE: begin
        if (rd) begin
          flits_left_d = head;
          state_d = (head == '0) ? S_IDLE : S_PAYLOAD;
        end
      end
      S_PAYLOAD: begin
        if (rd) begin
          flits_left_d = flits_left_q - FLIT_SIZE'(1);
          if (flits_left_q == FLIT_SIZE'(1)) state_d = S_IDLE;
        end
      end
      default: state_d = S_IDLE;
    endcase
  end

  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      state_q      <= S_IDLE;
      flits_left_q <= '0;
    end else begin
      state_q      <= state_d;
      flits_left_q <= flits_left_d;
    end
  end

endmodule

// File: tb/tb_hermes_input_buffer.sv
// Bench for hermes_input_buffer: vector table, corner sequences, random traffic.
// A queue-based packet model predicts every output each cycle.
module tb_hermes_input_buffer;

  logic clk = 1'b0;
  logic rst_n = 1'b0;
  always #5 clk = ~clk;

  hermes_input_buffer_if #(.FLIT_SIZE(32)) bus ();

  hermes_input_buffer #(
    .FLIT_SIZE   (32),
    .BUFFER_SIZE (8)
  ) dut (
    .clk_i  (clk),
    .rst_ni (rst_n),
    .bus    (bus)
  );

  int n_tests = 0;
  int n_fail  = 0;
  int n_rd    = 0;
  bit h_seen  = 0;

  logic [31:0] m_q [$];
  logic [31:0] tx [$];
  bit          m_req, m_grant;
  int          m_pos;
  logic [31:0] m_left;

  typedef struct {
    logic rx; logic [31:0] d; logic ah; logic da;
    logic c; logic h; logic av; logic [31:0] q; logic s;
  } vec_t;
  vec_t tbl [16];

  task automatic chk(input string nm, input logic [31:0] act,
                     input logic [31:0] exp);
    n_tests++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %h expected %h", nm, act, exp);
    end
  endtask

  task automatic model_reset();
    m_q.delete();
    m_req = 0; m_grant = 0; m_pos = 0; m_left = '0;
  endtask

  // Packet-level view: header, size word, then size payload flits.
  task automatic model_tick(input logic rx, input logic [31:0] d,
                            input logic ah, input logic da);
    bit cr, av, w, r;
    logic [31:0] hd;
    cr = m_q.size() < 8;
    av = m_grant && m_q.size() > 0;
    hd = (m_q.size() > 0) ? m_q[0] : '0;
    w = rx && cr;
    r = av && da;
    if (!m_req && !m_grant) begin
      if (m_q.size() > 0) m_req = 1;
    end else if (m_req) begin
      if (ah) begin m_req = 0; m_grant = 1; m_pos = 0; end
    end else if (r) begin
      if (m_pos == 0) m_pos = 1;
      else if (m_pos == 1) begin
        if (hd == 0) m_grant = 0;
        else begin m_left = hd; m_pos = 2; end
      end else begin
        m_left = m_left - 1;
        if (m_left == 0) m_grant = 0;
      end
    end
    if (r) void'(m_q.pop_front());
    if (w) m_q.push_back(d);
  endtask

  task automatic step(input logic rx, input logic [31:0] d,
                      input logic ah, input logic da);
    bit av;
    bus.rx_i = rx; bus.data_i = d;
    bus.ack_h_i = ah; bus.data_ack_i = da;
    #1;
    av = m_grant && m_q.size() > 0;
    chk("credit", 32'(bus.credit_o), 32'(m_q.size() < 8));
    chk("h", 32'(bus.h_o), 32'(m_req));
    chk("data_av", 32'(bus.data_av_o), 32'(av));
    chk("data", bus.data_o, av ? m_q[0] : 32'h0);
    chk("sending", 32'(bus.sending_o), 32'(m_grant));
    if (bus.h_o) h_seen = 1;
    if (bus.data_av_o && da) n_rd++;
    model_tick(rx, d, ah, da);
    @(posedge clk);
    @(negedge clk);
  endtask

  task automatic drive_stream(input bit rnd, input int budget);
    int cyc = 0;
    logic rx, ah, da;
    logic [31:0] d;
    bit acc;
    while ((tx.size() > 0 || m_q.size() > 0 || m_req || m_grant)
           && cyc < budget) begin
      rx = tx.size() > 0 && (!rnd || $urandom_range(3) != 0);
      d = (tx.size() > 0) ? tx[0] : 32'h0;
      acc = rx && m_q.size() < 8;
      ah = rnd ? 1'($urandom_range(1)) : 1'b1;
      da = rnd ? ($urandom_range(2) != 0) : 1'b1;
      step(rx, d, ah, da);
      if (acc) void'(tx.pop_front());
      cyc++;
    end
    chk("stream_done_in_budget", 32'(cyc < budget), 32'd1);
  endtask

  task automatic chk_reset_outs(input string nm);
    chk({nm, "_credit"}, 32'(bus.credit_o), 32'd1);
    chk({nm, "_h"}, 32'(bus.h_o), 32'd0);
    chk({nm, "_av"}, 32'(bus.data_av_o), 32'd0);
    chk({nm, "_data"}, bus.data_o, 32'd0);
    chk({nm, "_sending"}, 32'(bus.sending_o), 32'd0);
  endtask

  initial begin
    int reads;
    bus.rx_i = 0; bus.data_i = '0; bus.ack_h_i = 0; bus.data_ack_i = 0;
    model_reset();

    tbl[0]  = '{1'b1, 32'h11, 1'b0, 1'b1, 1'b1, 1'b0, 1'b0, 32'h0,  1'b0};
    tbl[1]  = '{1'b1, 32'h2,  1'b0, 1'b1, 1'b1, 1'b0, 1'b0, 32'h0,  1'b0};
    tbl[2]  = '{1'b1, 32'hA,  1'b0, 1'b1, 1'b1, 1'b1, 1'b0, 32'h0,  1'b0};
    tbl[3]  = '{1'b1, 32'hB,  1'b1, 1'b1, 1'b1, 1'b1, 1'b0, 32'h0,  1'b0};
    tbl[4]  = '{1'b0, 32'h0,  1'b0, 1'b1, 1'b1, 1'b0, 1'b1, 32'h11, 1'b1};
    tbl[5]  = '{1'b0, 32'h0,  1'b0, 1'b1, 1'b1, 1'b0, 1'b1, 32'h2,  1'b1};
    tbl[6]  = '{1'b0, 32'h0,  1'b0, 1'b1, 1'b1, 1'b0, 1'b1, 32'hA,  1'b1};
    tbl[7]  = '{1'b0, 32'h0,  1'b0, 1'b1, 1'b1, 1'b0, 1'b1, 32'hB,  1'b1};
    tbl[8]  = '{1'b0, 32'h0,  1'b0, 1'b1, 1'b1, 1'b0, 1'b0, 32'h0,  1'b0};
    tbl[9]  = '{1'b1, 32'h22, 1'b0, 1'b1, 1'b1, 1'b0, 1'b0, 32'h0,  1'b0};
    tbl[10] = '{1'b1, 32'h0,  1'b0, 1'b1, 1'b1, 1'b0, 1'b0, 32'h0,  1'b0};
    tbl[11] = '{1'b0, 32'h0,  1'b1, 1'b1, 1'b1, 1'b1, 1'b0, 32'h0,  1'b0};
    tbl[12] = '{1'b0, 32'h0,  1'b0, 1'b1, 1'b1, 1'b0, 1'b1, 32'h22, 1'b1};
    tbl[13] = '{1'b0, 32'h0,  1'b0, 1'b1, 1'b1, 1'b0, 1'b1, 32'h0,  1'b1};
    tbl[14] = '{1'b0, 32'h0,  1'b0, 1'b1, 1'b1, 1'b0, 1'b0, 32'h0,  1'b0};
    tbl[15] = '{1'b0, 32'h0,  1'b0, 1'b1, 1'b1, 1'b0, 1'b0, 32'h0,  1'b0};

    // Reset held, then released with rx idle.
    repeat (3) @(negedge clk);
    chk_reset_outs("in_reset");
    rst_n = 1'b1;
    repeat (3) step(1'b0, 32'h0, 1'b0, 1'b0);
    chk_reset_outs("post_reset");

    // Normal packet followed by a zero-size packet.
    for (int i = 0; i < 16; i++) begin
      bus.rx_i = tbl[i].rx; bus.data_i = tbl[i].d;
      bus.ack_h_i = tbl[i].ah; bus.data_ack_i = tbl[i].da;
      #1;
      chk($sformatf("v%0d_credit", i), 32'(bus.credit_o), 32'(tbl[i].c));
      chk($sformatf("v%0d_h", i), 32'(bus.h_o), 32'(tbl[i].h));
      chk($sformatf("v%0d_av", i), 32'(bus.data_av_o), 32'(tbl[i].av));
      chk($sformatf("v%0d_data", i), bus.data_o, tbl[i].q);
      chk($sformatf("v%0d_send", i), 32'(bus.sending_o), 32'(tbl[i].s));
      model_tick(tbl[i].rx, tbl[i].d, tbl[i].ah, tbl[i].da);
      @(posedge clk);
      @(negedge clk);
    end

    // Full buffer: ninth write dropped; credit back one cycle after a read.
    for (int i = 0; i < 9; i++) begin
      logic [31:0] f;
      f = (i == 0) ? 32'h33 : (i == 1) ? 32'd6 :
          (i == 8) ? 32'hDEAD : 32'h3300 + 32'(i);
      step(1'b1, f, 1'b0, 1'b0);
      if (i == 7) chk("credit_after_8th", 32'(bus.credit_o), 32'd0);
    end
    chk("credit_after_9th", 32'(bus.credit_o), 32'd0);
    step(1'b0, 32'h0, 1'b1, 1'b0);
    step(1'b0, 32'h0, 1'b0, 1'b1);
    chk("credit_after_read", 32'(bus.credit_o), 32'd1);
    tx.delete();
    drive_stream(1'b0, 40);
    repeat (3) step(1'b0, 32'h0, 1'b0, 1'b1);
    chk("ninth_not_stored_av", 32'(bus.data_av_o), 32'd0);
    chk("ninth_not_stored_h", 32'(bus.h_o), 32'd0);

    // Concurrent read and write at depth 4, pointers wrap.
    step(1'b1, 32'h44, 1'b0, 1'b0);
    step(1'b1, 32'd20, 1'b0, 1'b0);
    step(1'b1, 32'h4400, 1'b0, 1'b0);
    step(1'b1, 32'h4401, 1'b0, 1'b0);
    step(1'b0, 32'h0, 1'b1, 1'b0);
    for (int i = 2; i < 12; i++)
      step(1'b1, 32'h4400 + 32'(i), 1'b0, 1'b1);
    reads = 0;
    while (bus.data_av_o && reads < 10) begin
      step(1'b0, 32'h0, 1'b0, 1'b1);
      reads++;
    end
    chk("rdwr_depth_kept", 32'(reads), 32'd4);
    chk("bubble_av", 32'(bus.data_av_o), 32'd0);
    chk("bubble_sending", 32'(bus.sending_o), 32'd1);
    for (int i = 12; i < 20; i++) tx.push_back(32'h4400 + 32'(i));
    drive_stream(1'b0, 100);

    // Reset in mid-payload, then a fresh packet.
    step(1'b1, 32'h55, 1'b0, 1'b0);
    step(1'b1, 32'd5, 1'b0, 1'b0);
    for (int i = 0; i < 5; i++)
      step(1'b1, 32'h5500 + 32'(i), 1'b0, 1'b0);
    step(1'b0, 32'h0, 1'b1, 1'b0);
    repeat (4) step(1'b0, 32'h0, 1'b0, 1'b1);
    chk("mid_payload_sending", 32'(bus.sending_o), 32'd1);
    rst_n = 1'b0;
    #1;
    chk_reset_outs("mid_reset");
    @(negedge clk);
    rst_n = 1'b1;
    model_reset();
    bus.rx_i = 0; bus.ack_h_i = 0; bus.data_ack_i = 0;
    step(1'b0, 32'h0, 1'b0, 1'b0);
    tx = '{32'h66, 32'd2, 32'h6601, 32'h6602};
    h_seen = 0; n_rd = 0;
    drive_stream(1'b0, 100);
    chk("post_reset_h_seen", 32'(h_seen), 32'd1);
    chk("post_reset_reads", 32'(n_rd), 32'd4);

    // Random traffic against the model.
    for (int p = 0; p < 40; p++) begin
      int sz;
      sz = $urandom_range(6);
      tx.push_back(32'h7000_0000 + 32'(p));
      tx.push_back(32'(sz));
      for (int k = 0; k < sz; k++) tx.push_back($urandom);
    end
    drive_stream(1'b1, 5000);

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
